cpu_control: RTL and testbench

CPU_CONTROL -- requirements
Module: cpu_control

---
 rtl/cpu_control.sv | 161 ++++++++++++++++
 tb/tb_cpu_control.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_control.sv
// Multi-cycle control unit for an 8-bit accumulator-less CPU: a Moore FSM that
// sequences fetch, decode, immediate fetch, execute and halt, and drives datapath strobes.
module cpu_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irvalue,
  input  logic       zero,
  input  logic       negative,
  output logic       irload,
  output logic       imload,
  output logic       pcsel,
  output logic       pcload,
  output logic       readwrite,
  output logic       dwrite,
  output logic [1:0] dregsel,
  output logic [1:0] sregsel,
  output logic [1:0] aluop,
  output logic [1:0] regsel,
  output logic [1:0] addrsel,
  output logic [2:0] state,
  output logic       halted,
  output logic       instdone
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_IMM    = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_LI  = 4'h5;
  localparam logic [3:0] OP_LD  = 4'h6;
  localparam logic [3:0] OP_ST  = 4'h7;
  localparam logic [3:0] OP_LDR = 4'h8;
  localparam logic [3:0] OP_STR = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JZ  = 4'hB;
  localparam logic [3:0] OP_JN  = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     cur, nxt;
  logic [3:0] opcode;

  assign opcode = irvalue[7:4];
  assign state  = cur;

  // Instructions carrying an immediate/address byte after the opcode byte.
  function automatic logic is_two_byte(input logic [3:0] op);
    return (op == OP_LI) || (op == OP_LD) || (op == OP_ST) ||
           (op == OP_JMP) || (op == OP_JZ) || (op == OP_JN);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_RESET;
    else        cur <= nxt;
  end

  always_comb begin
    nxt       = S_FETCH;
    irload    = 1'b0;
    imload    = 1'b0;
    pcsel     = 1'b0;
    pcload    = 1'b0;
    readwrite = 1'b0;
    dwrite    = 1'b0;
    dregsel   = 2'b00;
    sregsel   = 2'b00;
    aluop     = 2'b00;
    regsel    = 2'b00;
    addrsel   = 2'b00;
    halted    = 1'b0;
    instdone  = 1'b0;
    case (cur)
      S_RESET: nxt = S_FETCH;
      S_FETCH: begin
        irload = 1'b1;
        pcload = 1'b1;
        nxt    = S_DECODE;
      end
      S_DECODE: begin
        dregsel = irvalue[3:2];
        sregsel = irvalue[1:0];
        if (opcode == OP_HLT)          nxt = S_HALT;
        else if (is_two_byte(opcode))  nxt = S_IMM;
        else                           nxt = S_EXEC;
      end
      S_IMM: begin
        imload = 1'b1;
        pcload = 1'b1;
        nxt    = S_EXEC;
      end
      S_EXEC: begin
        dregsel  = irvalue[3:2];
        sregsel  = irvalue[1:0];
        instdone = 1'b1;
        nxt      = S_FETCH;
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            aluop  = opcode[1:0] - 2'd1;
            dwrite = 1'b1;
          end
          OP_LI: begin
            regsel = 2'b01;
            dwrite = 1'b1;
          end
          OP_LD: begin
            addrsel = 2'b01;
            regsel  = 2'b10;
            dwrite  = 1'b1;
          end
          OP_ST: begin
            addrsel   = 2'b01;
            readwrite = 1'b1;
          end
          OP_LDR: begin
            addrsel = 2'b10;
            regsel  = 2'b10;
            dwrite  = 1'b1;
          end
          OP_STR: begin
            addrsel   = 2'b10;
            readwrite = 1'b1;
          end
          OP_JMP: begin
            pcsel  = 1'b1;
            pcload = 1'b1;
          end
          // Flags are only looked at here, in the cycle the PC is conditionally loaded.
          OP_JZ: begin
            pcsel  = 1'b1;
            pcload = zero;
          end
          OP_JN: begin
            pcsel  = 1'b1;
            pcload = negative;
          end
          OP_MOV: begin
            regsel = 2'b11;
            dwrite = 1'b1;
          end
          default: ;
        endcase
      end
      S_HALT: begin
        halted = 1'b1;
        nxt    = S_HALT;
      end
      default: nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_cpu_control.sv
// Bench for cpu_control: directed scenarios plus random instructions, each compared
// cycle by cycle against an instruction-level model of the control sequence.
module tb_cpu_control;

  logic       clk, rst_n;
  logic [7:0] irvalue;
  logic       zero, negative;
  logic       irload, imload, pcsel, pcload, readwrite, dwrite;
  logic [1:0] dregsel, sregsel, aluop, regsel, addrsel;
  logic [2:0] state;
  logic       halted, instdone;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       irload, imload, pcsel, pcload, readwrite, dwrite;
    logic [1:0] dregsel, sregsel, aluop, regsel, addrsel;
    logic [2:0] state;
    logic       halted, instdone;
  } ctl_t;

  cpu_control dut (
    .clk(clk), .rst_n(rst_n), .irvalue(irvalue), .zero(zero), .negative(negative),
    .irload(irload), .imload(imload), .pcsel(pcsel), .pcload(pcload),
    .readwrite(readwrite), .dwrite(dwrite), .dregsel(dregsel), .sregsel(sregsel),
    .aluop(aluop), .regsel(regsel), .addrsel(addrsel), .state(state),
    .halted(halted), .instdone(instdone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  function automatic ctl_t observe();
    ctl_t o;
    o = '{irload, imload, pcsel, pcload, readwrite, dwrite, dregsel, sregsel,
          aluop, regsel, addrsel, state, halted, instdone};
    return o;
  endfunction

  // Opcodes with an extra immediate byte, straight from the instruction set list.
  function automatic bit two_byte(input logic [3:0] op);
    logic [3:0] list [6] = '{4'h5, 4'h6, 4'h7, 4'hA, 4'hB, 4'hC};
    foreach (list[i]) if (list[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Expected outputs for one cycle of an instruction, given which phase it is in.
  function automatic ctl_t expect_cycle(input int ph, input logic [7:0] ir,
                                        input logic z, input logic n);
    ctl_t c;
    int   op;
    c = '0;
    op = int'(ir[7:4]);
    c.state = 3'(ph);
    case (ph)
      1: begin c.irload = 1; c.pcload = 1; end
      2: begin c.dregsel = ir[3:2]; c.sregsel = ir[1:0]; end
      3: begin c.imload = 1; c.pcload = 1; end
      4: begin
        c.dregsel = ir[3:2]; c.sregsel = ir[1:0]; c.instdone = 1;
        if (op >= 1 && op <= 4) begin c.aluop = 2'(op - 1); c.dwrite = 1; end
        case (op)
          5:  begin c.regsel = 2'b01; c.dwrite = 1; end
          6:  begin c.addrsel = 2'b01; c.regsel = 2'b10; c.dwrite = 1; end
          7:  begin c.addrsel = 2'b01; c.readwrite = 1; end
          8:  begin c.addrsel = 2'b10; c.regsel = 2'b10; c.dwrite = 1; end
          9:  begin c.addrsel = 2'b10; c.readwrite = 1; end
          10: begin c.pcsel = 1; c.pcload = 1; end
          11: begin c.pcsel = 1; c.pcload = z; end
          12: begin c.pcsel = 1; c.pcload = n; end
          13: begin c.regsel = 2'b11; c.dwrite = 1; end
          default: ;
        endcase
      end
      5: c.halted = 1;
      default: ;
    endcase
    return c;
  endfunction

  task automatic check(input string tag, input ctl_t exp);
    ctl_t obs;
    obs = observe();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    checks++;
    assert (!(obs.readwrite && obs.dwrite) && !(obs.irload && obs.imload)) else begin
      errors++;
      $error("FAIL %s_exclusive observed=%h expected=no rw/dwrite or irload/imload overlap",
             tag, obs);
    end
  endtask

  // Asserts reset now (between edges), checks it is immediate, then releases it
  // and checks the first FETCH. Leaves the bench #1 after an edge, in FETCH.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1 check({tag, "_async"}, expect_cycle(0, irvalue, zero, negative));
    repeat (2) @(posedge clk);
    #1 check({tag, "_held"}, expect_cycle(0, irvalue, zero, negative));
    rst_n = 1'b1;
    #1 check({tag, "_released"}, expect_cycle(0, irvalue, zero, negative));
    @(posedge clk);
    #1 check({tag, "_first_fetch"}, expect_cycle(1, irvalue, zero, negative));
  endtask

  // Runs one instruction starting in FETCH; ends in the following FETCH (or in HALT).
  task automatic run_instr(input logic [7:0] ir, input logic z, input logic n);
    int path[$];
    irvalue = ir; zero = z; negative = n;
    path = '{1, 2};
    if (ir[7:4] == 4'hF) path.push_back(5);
    else begin
      if (two_byte(ir[7:4])) path.push_back(3);
      path.push_back(4);
    end
    foreach (path[i]) begin
      if (i > 0) begin @(posedge clk); #1; end
      check($sformatf("ir%02h_z%0d_n%0d_ph%0d", ir, z, n, path[i]),
            expect_cycle(path[i], ir, z, n));
    end
    if (ir[7:4] != 4'hF) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [7:0] r;
    rst_n = 1'b0; irvalue = 8'h00; zero = 1'b0; negative = 1'b0;
    #3;
    do_reset("por");

    run_instr(8'h00, 0, 0);
    check("after_nop_fetch", expect_cycle(1, 8'h00, 0, 0));
    run_instr(8'h16, 0, 0);
    run_instr(8'hB0, 1, 0);
    run_instr(8'hB0, 0, 1);
    run_instr(8'hC5, 0, 1);
    run_instr(8'hC5, 1, 0);
    run_instr(8'h73, 0, 0);
    run_instr(8'hA2, 0, 0);
    run_instr(8'hE7, 1, 1);

    // Random instruction stream, halting opcode excluded.
    for (int k = 0; k < 80; k++) begin
      r = 8'($urandom);
      if (r[7:4] == 4'hF) r[7:4] = 4'($urandom_range(0, 14));
      run_instr(r, 1'($urandom), 1'($urandom));
    end

    // Abort a store in its write cycle.
    irvalue = 8'h91; zero = 0; negative = 0;
    check("str_fetch", expect_cycle(1, 8'h91, 0, 0));
    @(posedge clk); #1 check("str_decode", expect_cycle(2, 8'h91, 0, 0));
    @(posedge clk); #1 check("str_exec", expect_cycle(4, 8'h91, 0, 0));
    #2;
    do_reset("str_abort");

    // Halt, hold, and recover only through reset.
    run_instr(8'hF0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      irvalue = 8'($urandom); zero = 1'($urandom); negative = 1'($urandom);
      @(posedge clk); #1 check($sformatf("halt_hold%0d", k), expect_cycle(5, irvalue, zero, negative));
    end
    #2;
    do_reset("halt_exit");
    run_instr(8'h4D, 0, 0);
    run_instr(8'h5B, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
